// File: rtl/framebuffer_arbiter.sv
// rtl/framebuffer_arbiter.sv - framebuffer RAM arbiter: VGA scan-out reads, queued engine writes, full-frame clear
// Display slots always win the single RAM port; queued writes and clear fills use every other cycle.
module framebuffer_arbiter #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int COLOR_W    = 8,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4,
  parameter logic [COLOR_W-1:0] BLANK_COLOR = '0
) (
  input  logic               real100clock,
  input  logic               resetn,
  input  logic               pixelPhase,
  input  logic               displayActive,
  input  logic [9:0]         xPixel,
  input  logic [8:0]         yPixel,
  output logic [COLOR_W-1:0] pixelColor,
  input  logic               wrValid,
  output logic               wrReady,
  input  logic [9:0]         wrX,
  input  logic [8:0]         wrY,
  input  logic [COLOR_W-1:0] wrColor,
  input  logic               clearStart,
  input  logic [COLOR_W-1:0] clearColor,
  output logic               clearBusy,
  output logic [2:0]         fifoLevel,
  output logic [ADDR_W-1:0]  memAddr,
  output logic               memWe,
  output logic [COLOR_W-1:0] memWdata,
  input  logic [COLOR_W-1:0] memRdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int E_W   = 10 + 9 + COLOR_W;
  localparam logic [2:0]        DEPTH_CNT = 3'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
    return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  endfunction

  function automatic logic in_range(input logic [9:0] x, input logic [8:0] y);
    return (32'(x) < 32'(WIDTH)) && (32'(y) < 32'(HEIGHT));
  endfunction

  logic [0:0]         state;
  logic [ADDR_W-1:0]  clear_addr;
  logic [COLOR_W-1:0] clear_color;

  logic [E_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [2:0]         fifo_count;

  logic               display_slot;
  logic               rd_in_range;
  logic               push;
  logic               pop;
  logic               clear_wr;
  logic [9:0]         head_x;
  logic [8:0]         head_y;
  logic [COLOR_W-1:0] head_color;
  logic               head_in_range;

  // Read tag pipeline: upd marks cycles that refresh pixelColor, rd marks a real RAM read.
  logic               p0_upd;
  logic               p0_rd;
  logic               p1_upd;
  logic               p1_rd;

  assign display_slot  = displayActive & pixelPhase;
  assign rd_in_range   = in_range(xPixel, yPixel);
  assign wrReady       = (fifo_count != DEPTH_CNT);
  assign fifoLevel     = fifo_count;
  assign clearBusy     = (state == ST_CLEAR);
  assign push          = wrValid & wrReady;
  assign pop           = !display_slot && (state == ST_IDLE) && (fifo_count != 3'd0);
  assign clear_wr      = !display_slot && (state == ST_CLEAR);
  assign {head_x, head_y, head_color} = fifo_mem[rd_ptr];
  assign head_in_range = in_range(head_x, head_y);

  always_ff @(posedge real100clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {wrX, wrY, wrColor};
    end
  end

  always_ff @(posedge real100clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // clearStart is only honoured in IDLE, so a pop issued that same cycle completes first.
  always_ff @(posedge real100clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      clear_addr  <= '0;
      clear_color <= '0;
    end else if (state == ST_IDLE) begin
      if (clearStart) begin
        state       <= ST_CLEAR;
        clear_addr  <= '0;
        clear_color <= clearColor;
      end
    end else if (clear_wr) begin
      clear_addr <= clear_addr + ADDR_W'(1);
      if (clear_addr == LAST_ADDR) begin
        state <= ST_IDLE;
      end
    end
  end

  always_ff @(posedge real100clock or negedge resetn) begin
    if (!resetn) begin
      memAddr  <= '0;
      memWe    <= 1'b0;
      memWdata <= '0;
    end else begin
      memWe <= 1'b0;
      if (display_slot) begin
        if (rd_in_range) begin
          memAddr <= pix_addr(xPixel, yPixel);
        end
      end else if (clear_wr) begin
        memAddr  <= clear_addr;
        memWe    <= 1'b1;
        memWdata <= clear_color;
      end else if (pop && head_in_range) begin
        memAddr  <= pix_addr(head_x, head_y);
        memWe    <= 1'b1;
        memWdata <= head_color;
      end
    end
  end

  always_ff @(posedge real100clock or negedge resetn) begin
    if (!resetn) begin
      p0_upd     <= 1'b0;
      p0_rd      <= 1'b0;
      p1_upd     <= 1'b0;
      p1_rd      <= 1'b0;
      pixelColor <= BLANK_COLOR;
    end else begin
      p0_upd <= !displayActive || pixelPhase;
      p0_rd  <= display_slot && rd_in_range;
      p1_upd <= p0_upd;
      p1_rd  <= p0_rd;
      if (p1_upd) begin
        pixelColor <= p1_rd ? memRdata : BLANK_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb/tb_framebuffer_arbiter.sv - directed bench for framebuffer_arbiter with a behavioural RAM
// A reduced frame height keeps the full-frame clear short while x addressing matches a 640-wide line.
module tb_framebuffer_arbiter;
  localparam int WIDTH   = 640;
  localparam int HEIGHT  = 8;
  localparam int COLOR_W = 8;
  localparam int ADDR_W  = 19;
  localparam int NPIX    = WIDTH * HEIGHT;
  localparam int RAM_AW  = 13;

  logic               real100clock = 1'b0;
  logic               resetn = 1'b1;
  logic               pixelPhase = 1'b0;
  logic               displayActive = 1'b0;
  logic [9:0]         xPixel = '0;
  logic [8:0]         yPixel = '0;
  logic [COLOR_W-1:0] pixelColor;
  logic               wrValid = 1'b0;
  logic               wrReady;
  logic [9:0]         wrX = '0;
  logic [8:0]         wrY = '0;
  logic [COLOR_W-1:0] wrColor = '0;
  logic               clearStart = 1'b0;
  logic [COLOR_W-1:0] clearColor = '0;
  logic               clearBusy;
  logic [2:0]         fifoLevel;
  logic [ADDR_W-1:0]  memAddr;
  logic               memWe;
  logic [COLOR_W-1:0] memWdata;
  logic [COLOR_W-1:0] memRdata;

  logic [7:0]         ram [NPIX];
  logic               pre_we = 1'b0;
  logic [RAM_AW-1:0]  pre_addr = '0;
  logic [7:0]         pre_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 real100clock = ~real100clock;

  framebuffer_arbiter #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W),
    .FIFO_DEPTH(4), .BLANK_COLOR(8'h00)
  ) dut (
    .real100clock(real100clock), .resetn(resetn),
    .pixelPhase(pixelPhase), .displayActive(displayActive),
    .xPixel(xPixel), .yPixel(yPixel), .pixelColor(pixelColor),
    .wrValid(wrValid), .wrReady(wrReady), .wrX(wrX), .wrY(wrY), .wrColor(wrColor),
    .clearStart(clearStart), .clearColor(clearColor), .clearBusy(clearBusy),
    .fifoLevel(fifoLevel), .memAddr(memAddr), .memWe(memWe), .memWdata(memWdata),
    .memRdata(memRdata)
  );

  always @(posedge real100clock) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (memWe) ram[memAddr[RAM_AW-1:0]] <= memWdata;
    memRdata <= ram[memAddr[RAM_AW-1:0]];
  end

  task automatic tick();
    @(posedge real100clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    pre_addr = RAM_AW'(a);
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    int n_wr;
    int bad;

    // Reset state
    #2 resetn = 1'b0;
    #1;
    check("rst_pixel", 32'(pixelColor), 0);
    check("rst_we", 32'(memWe), 0);
    check("rst_addr", 32'(memAddr), 0);
    check("rst_wdata", 32'(memWdata), 0);
    check("rst_ready", 32'(wrReady), 1);
    check("rst_level", 32'(fifoLevel), 0);
    check("rst_busy", 32'(clearBusy), 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    poke(645, 8'h3C);
    poke(646, 8'h5A);
    poke(640, 8'h99);

    // Display read: address after 1 clock, colour after 3
    displayActive = 1'b1; pixelPhase = 1'b1; xPixel = 10'd5; yPixel = 9'd1;
    tick();
    check("rd_addr", 32'(memAddr), 645);
    check("rd_we", 32'(memWe), 0);
    pixelPhase = 1'b0;
    tick();
    check("rd_early", 32'(pixelColor), 0);
    tick();
    check("rd_color", 32'(pixelColor), 32'h3C);

    // Reset mid-stream with queued writes and a blocked clear pending
    pixelPhase = 1'b1; xPixel = 10'd700; yPixel = 9'd0;
    wrValid = 1'b1; wrX = 10'd1; wrY = 9'd0; wrColor = 8'h21;
    clearStart = 1'b1; clearColor = 8'h42;
    tick();
    clearStart = 1'b0; wrColor = 8'h22;
    tick();
    wrValid = 1'b0;
    check("pre_rst_level", 32'(fifoLevel), 2);
    check("pre_rst_busy", 32'(clearBusy), 1);
    check("pre_rst_pixel", 32'(pixelColor), 32'h3C);
    resetn = 1'b0;
    #2;
    check("mid_rst_pixel", 32'(pixelColor), 0);
    check("mid_rst_we", 32'(memWe), 0);
    check("mid_rst_addr", 32'(memAddr), 0);
    check("mid_rst_ready", 32'(wrReady), 1);
    check("mid_rst_level", 32'(fifoLevel), 0);
    check("mid_rst_busy", 32'(clearBusy), 0);
    displayActive = 1'b0; pixelPhase = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    tick();
    check("post_rst_we", 32'(memWe), 0);
    check("post_rst_level", 32'(fifoLevel), 0);

    // Fill the FIFO while display slots block every write
    displayActive = 1'b1; pixelPhase = 1'b1; xPixel = 10'd700; yPixel = 9'd0;
    for (int i = 0; i < 4; i++) begin
      wrValid = 1'b1; wrX = 10'(i); wrY = 9'd2; wrColor = 8'(8'h10 + i);
      tick();
      check("fill_level", 32'(fifoLevel), 32'(i + 1));
    end
    check("full_ready", 32'(wrReady), 0);
    wrX = 10'd4; wrColor = 8'h14;
    displayActive = 1'b0; pixelPhase = 1'b0;
    tick();
    check("drain0_addr", 32'(memAddr), 1280);
    check("drain0_we", 32'(memWe), 1);
    check("drain0_data", 32'(memWdata), 32'h10);
    check("drain0_ready", 32'(wrReady), 1);
    tick();
    wrValid = 1'b0;
    check("drain1_addr", 32'(memAddr), 1281);
    check("drain1_level", 32'(fifoLevel), 3);
    tick();
    check("drain2_addr", 32'(memAddr), 1282);
    tick();
    check("drain3_addr", 32'(memAddr), 1283);
    tick();
    check("drain4_addr", 32'(memAddr), 1284);
    check("drain4_data", 32'(memWdata), 32'h14);
    check("drain4_we", 32'(memWe), 1);
    tick();
    check("drain_idle_we", 32'(memWe), 0);
    check("drain_idle_level", 32'(fifoLevel), 0);
    for (int i = 0; i < 5; i++) begin
      check("drain_ram", 32'(ram[RAM_AW'(1280 + i)]), 32'(8'h10 + i));
    end

    // Visible, alternating phase: write only in the phase-0 cycle
    displayActive = 1'b1; pixelPhase = 1'b1; xPixel = 10'd5; yPixel = 9'd1;
    wrValid = 1'b1; wrX = 10'd639; wrY = 9'd7; wrColor = 8'hAA;
    tick();
    wrValid = 1'b0;
    check("alt_rd_addr", 32'(memAddr), 645);
    check("alt_rd_we", 32'(memWe), 0);
    pixelPhase = 1'b0;
    tick();
    check("alt_wr_addr", 32'(memAddr), 5119);
    check("alt_wr_we", 32'(memWe), 1);
    check("alt_wr_data", 32'(memWdata), 32'hAA);
    pixelPhase = 1'b1; xPixel = 10'd6;
    tick();
    check("alt_rd2_addr", 32'(memAddr), 646);
    check("alt_rd2_we", 32'(memWe), 0);
    check("alt_pix0", 32'(pixelColor), 32'h3C);
    pixelPhase = 1'b0;
    tick();
    check("alt_pix_hold", 32'(pixelColor), 32'h3C);
    tick();
    check("alt_pix1", 32'(pixelColor), 32'h5A);
    check("alt_ram", 32'(ram[RAM_AW'(5119)]), 32'hAA);

    // Out-of-range write is popped and dropped
    displayActive = 1'b0; pixelPhase = 1'b0;
    wrValid = 1'b1; wrX = 10'd640; wrY = 9'd0; wrColor = 8'hBB;
    tick();
    wrValid = 1'b0;
    check("oor_level1", 32'(fifoLevel), 1);
    tick();
    check("oor_we", 32'(memWe), 0);
    check("oor_level0", 32'(fifoLevel), 0);
    check("oor_addr_held", 32'(memAddr), 646);
    tick();
    check("oor_ram", 32'(ram[RAM_AW'(640)]), 32'h99);

    // Out-of-range reads: no address change, blank colour
    displayActive = 1'b1; pixelPhase = 1'b1; xPixel = 10'd5; yPixel = 9'd1;
    tick();
    xPixel = 10'd700;
    tick();
    check("oor_rd_addr", 32'(memAddr), 645);
    check("oor_rd_we", 32'(memWe), 0);
    xPixel = 10'd5;
    tick();
    yPixel = 9'd8;
    tick();
    check("oor_rd_pix_a", 32'(pixelColor), 0);
    check("oor_rd_addr_y", 32'(memAddr), 645);
    pixelPhase = 1'b0;
    tick();
    check("oor_rd_pix_b", 32'(pixelColor), 32'h3C);
    tick();
    check("oor_rd_pix_c", 32'(pixelColor), 0);

    // Full-frame clear with a write queued mid-clear
    displayActive = 1'b0; yPixel = 9'd0;
    clearStart = 1'b1; clearColor = 8'h07;
    tick();
    clearStart = 1'b0; clearColor = 8'h55;
    check("clr_busy_start", 32'(clearBusy), 1);
    check("clr_we_start", 32'(memWe), 0);
    busy_cycles = 0; n_wr = 0; bad = 0;
    wrX = 10'd3; wrY = 9'd0; wrColor = 8'h77;
    for (int cyc = 0; cyc < NPIX + 100; cyc++) begin
      if (!clearBusy) break;
      busy_cycles++;
      wrValid = (cyc == 100);
      clearStart = (cyc == 200);
      tick();
      if (memWe) begin
        if (int'(memAddr) != n_wr || memWdata != 8'h07) bad++;
        n_wr++;
      end
    end
    wrValid = 1'b0; clearStart = 1'b0;
    check("clr_busy_end", 32'(clearBusy), 0);
    check("clr_busy_cycles", 32'(busy_cycles), 32'(NPIX));
    check("clr_writes", 32'(n_wr), 32'(NPIX));
    check("clr_bad_writes", 32'(bad), 0);
    check("clr_queued", 32'(fifoLevel), 1);
    tick();
    check("after_clr_addr", 32'(memAddr), 3);
    check("after_clr_we", 32'(memWe), 1);
    check("after_clr_data", 32'(memWdata), 32'h77);
    check("after_clr_level", 32'(fifoLevel), 0);
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (i != 3 && ram[RAM_AW'(i)] !== 8'h07) bad++;
    end
    check("clr_ram_fill", 32'(bad), 0);
    check("clr_ram_queued", 32'(ram[RAM_AW'(3)]), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
